// File: rtl/or8way_sweep_checker.sv
// Exhaustive sweep driver/checker for an OR-reduction unit: drives every input
// vector, samples the DUT response and compares it against a golden OR-reduce.
module or8way_sweep_checker #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned ERR_W  = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [WIDTH-1:0] stim,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] first_fail,
  output logic             ff_valid
);

  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CHECK,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] settle_cnt;
  logic             settle_last;
  logic             golden;
  logic             mismatch;
  logic             stim_last;
  logic [ERR_W-1:0] err_nxt;

  assign settle_last = (settle_cnt == CNT_W'(SETTLE - 1));
  assign golden      = |stim;
  assign mismatch    = (dut_out != golden);
  assign stim_last   = &stim;

  // Saturating increment so a badly broken DUT cannot wrap the count back to zero.
  always_comb begin
    err_nxt = err_count;
    if (mismatch && !(&err_count)) begin
      err_nxt = err_count + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   if (settle_last) state_nxt = CHECK;
      CHECK:   state_nxt = stim_last ? DONE : DRIVE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stim       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      first_fail <= '0;
      ff_valid   <= 1'b0;
      settle_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            stim       <= '0;
            busy       <= 1'b1;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
            ff_valid   <= 1'b0;
            settle_cnt <= '0;
          end
        end
        DRIVE: begin
          settle_cnt <= settle_last ? '0 : settle_cnt + CNT_W'(1);
        end
        CHECK: begin
          err_count <= err_nxt;
          if (mismatch && !ff_valid) begin
            first_fail <= stim;
            ff_valid   <= 1'b1;
          end
          // pass uses err_nxt so a mismatch on the final vector is still counted.
          if (stim_last) begin
            done <= 1'b1;
            busy <= 1'b0;
            pass <= (err_nxt == '0);
          end else begin
            stim <= stim + WIDTH'(1);
          end
        end
        DONE: begin
          done <= 1'b0;
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_or8way_sweep_checker.sv
// Directed bench for or8way_sweep_checker: behavioural OR DUT with selectable
// faults, plus a small parameterised instance that exercises error saturation.
module tb_or8way_sweep_checker;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] stim;
  logic       dut_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [8:0] err_count;
  logic [7:0] first_fail;
  logic       ff_valid;

  logic       s_start;
  logic [3:0] s_stim;
  logic       s_busy;
  logic       s_done;
  logic       s_pass;
  logic [2:0] s_err_count;
  logic [3:0] s_first_fail;
  logic       s_ff_valid;

  int mode;
  int checks;
  int failures;

  or8way_sweep_checker #(.WIDTH(8), .SETTLE(1), .ERR_W(9)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stim       (stim),
    .dut_out    (dut_out),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .first_fail (first_fail),
    .ff_valid   (ff_valid)
  );

  // Small instance: stuck-at-0 DUT, 3-bit error counter saturates at 7.
  or8way_sweep_checker #(.WIDTH(4), .SETTLE(3), .ERR_W(3)) sdut (
    .clk        (clk),
    .reset      (reset),
    .start      (s_start),
    .stim       (s_stim),
    .dut_out    (1'b0),
    .busy       (s_busy),
    .done       (s_done),
    .pass       (s_pass),
    .err_count  (s_err_count),
    .first_fail (s_first_fail),
    .ff_valid   (s_ff_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode 0: correct OR, 1: stuck-at-0, 2: inverted only for 8'h55
  always_comb begin
    dut_out = |stim;
    if (mode == 1) dut_out = 1'b0;
    else if (mode == 2 && stim == 8'h55) dut_out = ~(|stim);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Call right after the start-accept edge has been sampled.
  task automatic run_sweep(input int repulse_at, output int done_edge, output int busy_cycles);
    done_edge   = -1;
    busy_cycles = busy ? 1 : 0;
    for (int e = 1; e <= 700; e++) begin
      if (repulse_at != 0 && e == repulse_at) start = 1'b1;
      tick();
      if (repulse_at != 0 && e == repulse_at) start = 1'b0;
      if (busy) busy_cycles++;
      if (done) begin
        done_edge = e;
        break;
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic changed;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({stim, busy, done, pass, err_count, first_fail, ff_valid} !== '0) begin
      failures++;
      $display("FAIL reset_state: stim=%h busy=%b done=%b pass=%b err=%0d ff=%h ffv=%b required all zero",
               stim, busy, done, pass, err_count, first_fail, ff_valid);
    end
    changed = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if ({stim, busy, done, pass, err_count, first_fail, ff_valid} !== '0) changed = 1'b1;
    end
    checks++;
    if (changed !== 1'b0) begin
      failures++;
      $display("FAIL idle_quiet: outputs changed=%b required 0", changed);
    end
  endtask

  task automatic test_clean_sweep();
    int de, bc, extra;
    mode = 0;
    pulse_start();
    run_sweep(0, de, bc);
    checks++;
    if (de !== 512) begin
      failures++;
      $display("FAIL clean_done_edge: got %0d required 512", de);
    end
    checks++;
    if (bc !== 512) begin
      failures++;
      $display("FAIL clean_busy_cycles: got %0d required 512", bc);
    end
    checks++;
    if ({pass, err_count, ff_valid, stim} !== {1'b1, 9'd0, 1'b0, 8'hFF}) begin
      failures++;
      $display("FAIL clean_result: pass=%b err=%0d ffv=%b stim=%h required pass=1 err=0 ffv=0 stim=ff",
               pass, err_count, ff_valid, stim);
    end
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) extra++;
    end
    checks++;
    if (extra !== 0 || busy !== 1'b0 || pass !== 1'b1 || stim !== 8'hFF) begin
      failures++;
      $display("FAIL clean_hold: extra_done=%0d busy=%b pass=%b stim=%h required 0 0 1 ff",
               extra, busy, pass, stim);
    end
  endtask

  task automatic test_stuck_at_0();
    int de, bc;
    mode = 1;
    pulse_start();
    checks++;
    if ({busy, err_count, ff_valid, pass, stim} !== {1'b1, 9'd0, 1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL start_clears: busy=%b err=%0d ffv=%b pass=%b stim=%h required 1 0 0 0 00",
               busy, err_count, ff_valid, pass, stim);
    end
    run_sweep(0, de, bc);
    checks++;
    if ({err_count, first_fail, ff_valid, pass} !== {9'd255, 8'h01, 1'b1, 1'b0} || de !== 512) begin
      failures++;
      $display("FAIL stuck0_result: err=%0d ff=%h ffv=%b pass=%b edge=%0d required 255 01 1 0 512",
               err_count, first_fail, ff_valid, pass, de);
    end
    tick();
  endtask

  task automatic test_single_fault();
    int de, bc;
    mode = 2;
    pulse_start();
    run_sweep(0, de, bc);
    checks++;
    if ({err_count, first_fail, ff_valid, pass} !== {9'd1, 8'h55, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL single_fault: err=%0d ff=%h ffv=%b pass=%b required 1 55 1 0",
               err_count, first_fail, ff_valid, pass);
    end
    tick();
  endtask

  task automatic test_reset_mid_sweep();
    int de, bc;
    mode = 1;
    pulse_start();
    repeat (100) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({busy, stim, err_count, ff_valid, first_fail, done, pass} !== '0) begin
      failures++;
      $display("FAIL mid_reset: busy=%b stim=%h err=%0d ffv=%b ff=%h done=%b pass=%b required all zero",
               busy, stim, err_count, ff_valid, first_fail, done, pass);
    end
    tick();
    mode = 0;
    pulse_start();
    run_sweep(0, de, bc);
    checks++;
    if ({pass, err_count, ff_valid} !== {1'b1, 9'd0, 1'b0} || de !== 512) begin
      failures++;
      $display("FAIL post_reset_sweep: pass=%b err=%0d ffv=%b edge=%0d required 1 0 0 512",
               pass, err_count, ff_valid, de);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int de, bc;
    mode = 0;
    pulse_start();
    run_sweep(50, de, bc);
    checks++;
    if (de !== 512) begin
      failures++;
      $display("FAIL repulse_ignored: done edge %0d required 512", de);
    end
    tick();
    start = 1'b1;
    tick();
    run_sweep(0, de, bc);
    checks++;
    if (de !== 512) begin
      failures++;
      $display("FAIL held_first_done: done edge %0d required 512", de);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL gap_idle: busy=%b done=%b required 0 0", busy, done);
    end
    tick();
    checks++;
    if (busy !== 1'b1 || stim !== 8'h00) begin
      failures++;
      $display("FAIL second_start: busy=%b stim=%h required 1 00", busy, stim);
    end
    start = 1'b0;
    run_sweep(0, de, bc);
    checks++;
    if (de !== 512 || pass !== 1'b1) begin
      failures++;
      $display("FAIL second_sweep: done edge %0d pass=%b required 512 1", de, pass);
    end
    tick();
  endtask

  task automatic test_saturation();
    int de;
    de = -1;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int e = 1; e <= 200; e++) begin
      tick();
      if (s_done) begin
        de = e;
        break;
      end
    end
    checks++;
    if (de !== 64) begin
      failures++;
      $display("FAIL small_done_edge: got %0d required 64", de);
    end
    checks++;
    if ({s_err_count, s_first_fail, s_ff_valid, s_pass, s_stim} !== {3'd7, 4'h1, 1'b1, 1'b0, 4'hF}) begin
      failures++;
      $display("FAIL small_saturate: err=%0d ff=%h ffv=%b pass=%b stim=%h required 7 1 1 0 f",
               s_err_count, s_first_fail, s_ff_valid, s_pass, s_stim);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    mode     = 0;
    reset    = 1'b1;
    start    = 1'b0;
    s_start  = 1'b0;
    test_reset();
    test_clean_sweep();
    test_stuck_at_0();
    test_single_fault();
    test_reset_mid_sweep();
    test_back_to_back();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
